// File: rtl/online_digit_seq_pkg.sv
// Package: online_digit_seq_pkg
// Shared definitions for the online digit sequencer and its operand serializer.
//   - FSM state encoding (IDLE / STREAM / DONE)
//   - borrow-save digit constants, encoded {p,n} with value p-n
//   - derived-width helpers for the cycle count, result width and counter width
package online_digit_seq_pkg;

  // FSM states, kept as plain constants so older tools can read them.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // {p,n} digit encodings; 2'b11 is also zero but never generated here.
  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;

  // Cycles spent in STREAM: input digits, plus the online delay, plus growth digits.
  function automatic int f_ncyc(input int stage, input int delta, input int extra);
    return stage + delta + extra;
  endfunction

  // Result width in bits: one {p,n} pair per result digit.
  function automatic int f_wl_res(input int stage, input int extra);
    return 2 * (stage + extra);
  endfunction

  // Width of a counter that must hold ncyc-1.
  function automatic int f_kw(input int ncyc);
    return (ncyc <= 2) ? 1 : $clog2(ncyc);
  endfunction

  // True for a digit with a nonzero value.
  function automatic logic f_dig_nonzero(input logic [1:0] d);
    return (d == DIG_POS) || (d == DIG_NEG);
  endfunction

endpackage

// File: rtl/online_digit_ser.sv
// Module: online_digit_ser
// Per-operand MSD-first serializer. A parallel borrow-save operand is loaded,
// then shifted left one digit per enabled cycle; zeros fill in from the LSD
// end so the output reads as zero padding once the real digits are exhausted.
// Ports:
//   clk    in  1   clock
//   rst    in  1   synchronous active-high reset
//   load   in  1   capture din (has priority over shift)
//   shift  in  1   advance to the next digit
//   din    in  WL  operand, MSD in the top two bits
//   digit  out 2   current digit {p,n}
module online_digit_ser
  import online_digit_seq_pkg::*;
#(
  parameter int WL = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic [WL-1:0] din,
  output logic [1:0]    digit
);

  logic [WL-1:0] r_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh <= '0;
    end else if (load) begin
      r_sh <= din;
    end else if (shift) begin
      r_sh <= {r_sh[WL-3:0], DIG_ZERO};
    end
  end

  assign digit = r_sh[WL-1 -: 2];

endmodule

// File: rtl/online_digit_seq.sv
// Module: online_digit_seq
// Sequencer for a shared MSD-first online datapath. Accepts N_OPS borrow-save
// operands over valid/ready, streams them one digit per cycle (zero padded),
// gathers the datapath output digits after the online delay and returns the
// assembled redundant result over valid/ready.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   op_valid/op_ready     operand-set handshake
//   op_data               operand i in bits [i*WL +: WL]
//   dp_clr, dp_en         datapath clear / advance
//   dp_digit              current digit of operand i in bits [2i +: 2]
//   dp_out_digit          datapath output digit {p,n}
//   res_valid/res_ready   result handshake
//   res_data              result digits, MSD in the top two bits
// Optional build macro ONLINE_SEQ_STATS_EN adds:
//   ops_done[15:0]        result handshakes, wrapping
//   stall_cnt[15:0]       DONE cycles with res_ready low, saturating
module online_digit_seq
  import online_digit_seq_pkg::*;
#(
  parameter int Stage = 4,
  parameter int N_OPS = 3,
  parameter int DELTA = 2,
  parameter int EXTRA = 2,
  localparam int WL     = 2 * Stage,
  localparam int NCYC   = f_ncyc(Stage, DELTA, EXTRA),
  localparam int WL_RES = f_wl_res(Stage, EXTRA)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [N_OPS*WL-1:0] op_data,
  output logic                dp_clr,
  output logic                dp_en,
  output logic [2*N_OPS-1:0]  dp_digit,
  input  logic [1:0]          dp_out_digit,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WL_RES-1:0]   res_data
`ifdef ONLINE_SEQ_STATS_EN
  ,
  output logic [15:0]         ops_done,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int KW = f_kw(NCYC);

  logic [1:0]        r_state;
  logic [KW-1:0]     r_k;
  logic [WL_RES-1:0] r_res;

  logic w_stream;
  logic w_done;
  logic w_accept;
  logic w_last;
  logic [1:0] w_dig [N_OPS];

  assign w_stream = (r_state == ST_STREAM);
  assign w_done   = (r_state == ST_DONE);
  // Ready in DONE only alongside res_ready, so a new set can chain with no bubble.
  assign op_ready = (r_state == ST_IDLE) || (w_done && res_ready);
  assign w_accept = op_valid && op_ready;
  assign w_last   = w_stream && (r_k == KW'(NCYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_STREAM;
            r_k     <= '0;
          end
        end
        ST_STREAM: begin
          // Output digits only become meaningful after the online delay.
          if (r_k >= KW'(DELTA)) begin
            r_res <= {r_res[WL_RES-3:0], dp_out_digit};
          end
          if (w_last) begin
            r_state <= ST_DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            if (op_valid) begin
              r_state <= ST_STREAM;
              r_k     <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_OPS; gi++) begin : g_ser
      online_digit_ser #(.WL(WL)) u_ser (
        .clk   (clk),
        .rst   (rst),
        .load  (w_accept),
        .shift (w_stream),
        .din   (op_data[gi*WL +: WL]),
        .digit (w_dig[gi])
      );
      assign dp_digit[2*gi +: 2] = w_stream ? w_dig[gi] : DIG_ZERO;
    end
  endgenerate

  assign dp_en     = w_stream;
  assign dp_clr    = !w_stream;
  assign res_valid = w_done;
  assign res_data  = r_res;

`ifdef ONLINE_SEQ_STATS_EN
  logic [15:0] r_ops_done;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ops_done  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_done && res_ready) begin
        r_ops_done <= r_ops_done + 16'd1;
      end
      if (w_done && !res_ready && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign ops_done  = r_ops_done;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
